// File: rtl/mem_stream_packetizer_pkg.sv
// Shared word layout, field offsets and FSM encoding for the readout-stream packetizer.
// Word = {type[1:0], payload[44:0]}.
package mem_stream_pkg;
   localparam int DAT_W  = 45;
   localparam int WORD_W = 47;
   localparam int BX_W   = 3;
   localparam int SEQ_W  = 8;
   localparam int WCNT_W = 10;
   localparam int DCNT_W = 8;

   localparam logic [1:0] TYPE_HDR = 2'b01;
   localparam logic [1:0] TYPE_DAT = 2'b10;
   localparam logic [1:0] TYPE_TRL = 2'b11;

   localparam int BX_LSB    = 42;
   localparam int SEQ_LSB   = 34;
   localparam int WCNT_LSB  = 32;
   localparam int DCNT_LSB  = 24;
   localparam int TRUNC_BIT = 23;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      TRL  = 2'd3
   } state_t;
endpackage

// File: rtl/mem_stream_packetizer_if.sv
// Merged-stream input and packet output link of the packetizer.
// master = packetizer side, slave = merger/consumer side.
interface mem_stream_packetizer_if;
   import mem_stream_pkg::*;

   logic [DAT_W-1:0]  stream_dat;
   logic              stream_valid;
   logic              stream_send_BX;
   logic              stream_none;
   logic [WORD_W-1:0] out_dat;
   logic              out_valid;
   logic              out_ready;
   logic              out_par;

   modport master (
      input  stream_dat, stream_valid, stream_send_BX, stream_none, out_ready,
      output out_dat, out_valid, out_par
   );

   modport slave (
      output stream_dat, stream_valid, stream_send_BX, stream_none, out_ready,
      input  out_dat, out_valid, out_par
   );
endinterface

// File: rtl/mem_stream_packetizer_pkt_fifo.sv
// First-word-fall-through FIFO with a registered head; a write shows on rd_vld one edge later.
// MEM_STREAM_PARITY_EN adds a parity flop loaded together with rd_dat.
module pkt_fifo
   import mem_stream_pkg::*;
#(
   parameter int AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_dat,
   input  logic              rd_en,
   output logic [WORD_W-1:0] rd_dat,
   output logic              rd_vld,
   output logic              rd_par,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       free
);
   localparam int DEPTH = 1 << AW;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       mem_cnt, occ;
   logic              pop, push, load;

   // Occupancy counts the head register too, so the full depth is usable.
   assign occ   = mem_cnt + (AW+1)'(rd_vld);
   assign full  = (occ == (AW+1)'(DEPTH));
   assign empty = (occ == '0);
   assign free  = (AW+1)'(DEPTH) - occ;
   assign pop   = rd_vld && rd_en;
   assign push  = wr_en && (!full || pop);
   assign load  = (mem_cnt != '0) && (!rd_vld || pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_vld  <= 1'b0;
         rd_dat  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_dat <= mem[rd_ptr];
            rd_vld <= 1'b1;
         end else if (pop) begin
            rd_vld <= 1'b0;
         end
         mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(load);
      end
   end

`ifdef MEM_STREAM_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rd_par <= 1'b0;
      else if (load) rd_par <= ^mem[rd_ptr];
   end
`else
   assign rd_par = 1'b0;
`endif
endmodule

// File: rtl/mem_stream_packetizer.sv
// Frames the merged readout stream into header/data/trailer packets buffered in pkt_fifo.
// MEM_STREAM_PARITY_EN: registered even parity on out_dat and BX stamping of send_BX data words.
module mem_stream_packetizer
   import mem_stream_pkg::*;
#(
   parameter int FIFO_AW = 6,
   parameter int GUARD   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    new_event,
   input  logic [BX_W-1:0]         BX,
   mem_stream_packetizer_if.master bus,
   output logic                    busy,
   output logic                    overflow
);
   localparam int GW = $clog2(GUARD + 2);

   state_t            state, state_nxt;
   logic [BX_W-1:0]   bx_cur, bx_pend;
   logic              pending, trunc;
   logic [SEQ_W-1:0]  evt_seq;
   logic [WCNT_W-1:0] wcnt;
   logic [DCNT_W-1:0] dcnt;
   logic [GW-1:0]     guard;
   logic              wr_en, room, drop, stray, fifo_empty, unused_full;
   logic [WORD_W-1:0] wr_dat;
   logic [DAT_W-1:0]  payload;
   logic [FIFO_AW:0]  fifo_free;

   // Two entries stay reserved so a header and trailer always fit.
   assign room  = fifo_free > (FIFO_AW+1)'(2);
   assign drop  = (state == DATA) && bus.stream_valid && !room;
   assign stray = (state != DATA) && bus.stream_valid;
   assign busy  = (state != IDLE) || !fifo_empty || pending;

`ifndef MEM_STREAM_PARITY_EN
   logic unused_send_bx;
   assign unused_send_bx = bus.stream_send_BX;
`endif

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      payload   = '0;
      wr_dat    = '0;
      case (state)
         IDLE: if (new_event) state_nxt = HDR;
         HDR: begin
            payload[BX_LSB +: BX_W]   = bx_cur;
            payload[SEQ_LSB +: SEQ_W] = evt_seq;
            wr_en     = 1'b1;
            wr_dat    = {TYPE_HDR, payload};
            state_nxt = new_event ? TRL : DATA;
         end
         DATA: begin
            payload = bus.stream_dat;
`ifdef MEM_STREAM_PARITY_EN
            if (bus.stream_send_BX) payload[BX_LSB +: BX_W] = bx_cur;
`endif
            wr_en  = bus.stream_valid && room;
            wr_dat = {TYPE_DAT, payload};
            if (new_event || (bus.stream_none && guard == '0)) state_nxt = TRL;
         end
         TRL: begin
            payload[BX_LSB +: BX_W]     = bx_cur;
            payload[WCNT_LSB +: WCNT_W] = wcnt;
            payload[DCNT_LSB +: DCNT_W] = dcnt;
            payload[TRUNC_BIT]          = trunc;
            wr_en     = 1'b1;
            wr_dat    = {TYPE_TRL, payload};
            state_nxt = (pending || new_event) ? HDR : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bx_cur   <= '0;
         bx_pend  <= '0;
         pending  <= 1'b0;
         trunc    <= 1'b0;
         evt_seq  <= '0;
         wcnt     <= '0;
         dcnt     <= '0;
         guard    <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (drop || stray) overflow <= 1'b1;
         if (new_event && state != IDLE) bx_pend <= BX;
         if (state == TRL && state_nxt == HDR)  pending <= 1'b0;
         else if (new_event && state != IDLE)   pending <= 1'b1;
         // dcnt restarts once the trailer carries it, so strays between packets land in the next one.
         if (state == TRL)                               dcnt <= stray ? DCNT_W'(1) : '0;
         else if ((drop || stray) && dcnt != '1)         dcnt <= dcnt + 1'b1;
         case (state)
            IDLE: if (new_event) begin
               bx_cur <= BX;
               guard  <= GW'(GUARD);
            end
            HDR: begin
               evt_seq <= evt_seq + 1'b1;
               wcnt    <= '0;
               trunc   <= new_event;
            end
            DATA: begin
               if (guard != '0) guard <= guard - 1'b1;
               if (wr_en && wcnt != '1) wcnt <= wcnt + 1'b1;
               if (new_event) trunc <= 1'b1;
            end
            TRL: if (state_nxt == HDR) begin
               bx_cur <= new_event ? BX : bx_pend;
               guard  <= GW'(GUARD);
            end
            default: ;
         endcase
      end
   end

   pkt_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk    (clk),
      .rst    (reset),
      .wr_en  (wr_en),
      .wr_dat (wr_dat),
      .rd_en  (bus.out_ready),
      .rd_dat (bus.out_dat),
      .rd_vld (bus.out_valid),
      .rd_par (bus.out_par),
      .full   (unused_full),
      .empty  (fifo_empty),
      .free   (fifo_free)
   );
endmodule

// File: tb/tb_mem_stream_packetizer.sv
// Directed bench for mem_stream_packetizer: framing, guard, backpressure/overflow, truncation, reset.
// Accepted words are captured at the falling edge and compared with hand-built packets.
module tb_mem_stream_packetizer;
   logic       clk = 1'b0;
   logic       reset;
   logic       new_event;
   logic [2:0] BX;
   logic       busy, overflow;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;

   logic [46:0] rec_q[$];
   logic        par_q[$];
   int          cyc_q[$];
   logic [46:0] exp_q[$];

   mem_stream_packetizer_if bus();

   mem_stream_packetizer dut (
      .clk       (clk),
      .reset     (reset),
      .new_event (new_event),
      .BX        (BX),
      .bus       (bus),
      .busy      (busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         rec_q.push_back(bus.out_dat);
         par_q.push_back(bus.out_par);
         cyc_q.push_back(cyc);
      end
   end

   function automatic logic [46:0] hdr_w(input logic [2:0] bx, input logic [7:0] seq);
      return {2'b01, bx, seq, 34'd0};
   endfunction

   function automatic logic [46:0] dat_w(input logic [44:0] d);
      return {2'b10, d};
   endfunction

   function automatic logic [46:0] trl_w(input logic [2:0] bx, input logic [9:0] w,
                                         input logic [7:0] d, input logic t);
      return {2'b11, bx, w, d, t, 23'd0};
   endfunction

   function automatic logic exp_par(input logic [46:0] w);
`ifdef MEM_STREAM_PARITY_EN
      return ^w;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [2:0] bx, output int ev0);
      BX = bx;
      new_event = 1'b1;
      tick();
      ev0 = cyc;
      new_event = 1'b0;
   endtask

   task automatic wait_q(input int n, input int budget);
      for (int i = 0; i < budget && rec_q.size() < n; i++) tick();
   endtask

   task automatic clear_q();
      rec_q.delete();
      par_q.delete();
      cyc_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.out_dat !== 47'd0) begin bad++; $display("FAIL rst_out_dat got=%h exp=0", bus.out_dat); end
      total++; if (bus.out_par !== 1'b0) begin bad++; $display("FAIL rst_out_par got=%b exp=0", bus.out_par); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      int ev0;
      clear_q();
      bus.out_ready = 1'b1;
      pulse(3'd5, ev0);
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         bus.stream_valid = 1'b1;
         bus.stream_dat   = 45'h0AB_CDEF_0000 + 45'(i);
         tick();
      end
      bus.stream_valid = 1'b0;
      tick();
      bus.stream_none = 1'b1;
      wait_q(5, 60);
      bus.stream_none = 1'b0;
      repeat (2) tick();
      exp_q.push_back(hdr_w(3'd5, 8'd0));
      for (int i = 0; i < 3; i++) exp_q.push_back(dat_w(45'h0AB_CDEF_0000 + 45'(i)));
      exp_q.push_back(trl_w(3'd5, 10'd3, 8'd0, 1'b0));
      total++; if (rec_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", rec_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
         total++; if (rec_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, rec_q[i], exp_q[i]); end
         total++; if (par_q[i] !== exp_par(rec_q[i])) begin bad++; $display("FAIL basic_par[%0d] got=%b exp=%b", i, par_q[i], exp_par(rec_q[i])); end
      end
      if (cyc_q.size() > 1) begin
         total++; if (cyc_q[1] != ev0 + 5) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", cyc_q[1] - ev0, 5); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
   endtask

   task automatic test_empty();
      int ev0;
      clear_q();
      bus.out_ready = 1'b1;
      pulse(3'd3, ev0);
      bus.stream_none = 1'b1;
      wait_q(2, 40);
      bus.stream_none = 1'b0;
      repeat (2) tick();
      exp_q.push_back(hdr_w(3'd3, 8'd1));
      exp_q.push_back(trl_w(3'd3, 10'd0, 8'd0, 1'b0));
      total++; if (rec_q.size() != exp_q.size()) begin bad++; $display("FAIL empty_count got=%0d exp=%0d", rec_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
         total++; if (rec_q[i] !== exp_q[i]) begin bad++; $display("FAIL empty_word[%0d] got=%h exp=%h", i, rec_q[i], exp_q[i]); end
         total++; if (par_q[i] !== exp_par(rec_q[i])) begin bad++; $display("FAIL empty_par[%0d] got=%b exp=%b", i, par_q[i], exp_par(rec_q[i])); end
      end
      if (cyc_q.size() > 1) begin
         total++; if (cyc_q[1] < ev0 + 8) begin bad++; $display("FAIL empty_guard trailer at +%0d exp>=+8", cyc_q[1] - ev0); end
      end
   endtask

   task automatic test_overflow();
      int ev0;
      clear_q();
      bus.out_ready = 1'b0;
      pulse(3'd2, ev0);
      repeat (3) tick();
      for (int i = 0; i < 70; i++) begin
         bus.stream_valid = 1'b1;
         bus.stream_dat   = {5'h15, 40'(i)};
         tick();
      end
      bus.stream_valid = 1'b0;
      tick();
      bus.stream_none = 1'b1;
      repeat (4) tick();
      bus.stream_none = 1'b0;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%b exp=1", busy); end
      repeat (3) tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_dat !== hdr_w(3'd2, 8'd2)) begin
         bad++; $display("FAIL ovf_hold got=%b/%h exp=1/%h", bus.out_valid, bus.out_dat, hdr_w(3'd2, 8'd2));
      end
      bus.out_ready = 1'b1;
      wait_q(63, 200);
      repeat (2) tick();
      exp_q.push_back(hdr_w(3'd2, 8'd2));
      for (int i = 0; i < 61; i++) exp_q.push_back(dat_w({5'h15, 40'(i)}));
      exp_q.push_back(trl_w(3'd2, 10'd61, 8'd9, 1'b0));
      total++; if (rec_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", rec_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
         total++; if (rec_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_word[%0d] got=%h exp=%h", i, rec_q[i], exp_q[i]); end
         total++; if (par_q[i] !== exp_par(rec_q[i])) begin bad++; $display("FAIL ovf_par[%0d] got=%b exp=%b", i, par_q[i], exp_par(rec_q[i])); end
      end
   endtask

   task automatic test_trunc();
      int ev0, ev1;
      clear_q();
      bus.out_ready = 1'b1;
      pulse(3'd6, ev0);
      repeat (3) tick();
      for (int i = 0; i < 10; i++) begin
         bus.stream_valid = 1'b1;
         bus.stream_dat   = {5'h0A, 40'(i)};
         tick();
      end
      bus.stream_valid = 1'b0;
      repeat (6) tick();
      pulse(3'd1, ev1);
      repeat (3) tick();
      bus.stream_none = 1'b1;
      wait_q(14, 80);
      bus.stream_none = 1'b0;
      repeat (2) tick();
      total++; if (ev1 != ev0 + 20) begin bad++; $display("FAIL trunc_timing got=+%0d exp=+20", ev1 - ev0); end
      exp_q.push_back(hdr_w(3'd6, 8'd3));
      for (int i = 0; i < 10; i++) exp_q.push_back(dat_w({5'h0A, 40'(i)}));
      exp_q.push_back(trl_w(3'd6, 10'd10, 8'd0, 1'b1));
      exp_q.push_back(hdr_w(3'd1, 8'd4));
      exp_q.push_back(trl_w(3'd1, 10'd0, 8'd0, 1'b0));
      total++; if (rec_q.size() != exp_q.size()) begin bad++; $display("FAIL trunc_count got=%0d exp=%0d", rec_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
         total++; if (rec_q[i] !== exp_q[i]) begin bad++; $display("FAIL trunc_word[%0d] got=%h exp=%h", i, rec_q[i], exp_q[i]); end
         total++; if (par_q[i] !== exp_par(rec_q[i])) begin bad++; $display("FAIL trunc_par[%0d] got=%b exp=%b", i, par_q[i], exp_par(rec_q[i])); end
      end
   endtask

   task automatic test_reset_mid();
      int ev0;
      clear_q();
      bus.out_ready = 1'b0;
      pulse(3'd4, ev0);
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         bus.stream_valid = 1'b1;
         bus.stream_dat   = 45'(i + 100);
         tick();
      end
      bus.stream_valid = 1'b0;
      tick();
      total++; if (busy !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL rmid_pre busy/ovf got=%b/%b exp=1/1", busy, overflow); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_overflow got=%b exp=0", overflow); end
      tick();
      reset = 1'b0;
      tick();
      clear_q();
      bus.out_ready = 1'b1;
      pulse(3'd7, ev0);
      repeat (3) tick();
      bus.stream_none = 1'b1;
      wait_q(2, 40);
      bus.stream_none = 1'b0;
      repeat (2) tick();
      exp_q.push_back(hdr_w(3'd7, 8'd0));
      exp_q.push_back(trl_w(3'd7, 10'd0, 8'd0, 1'b0));
      total++; if (rec_q.size() != exp_q.size()) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", rec_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
         total++; if (rec_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_word[%0d] got=%h exp=%h", i, rec_q[i], exp_q[i]); end
         total++; if (par_q[i] !== exp_par(rec_q[i])) begin bad++; $display("FAIL rmid_par[%0d] got=%b exp=%b", i, par_q[i], exp_par(rec_q[i])); end
      end
   endtask

   initial begin
      reset              = 1'b1;
      new_event          = 1'b0;
      BX                 = 3'd0;
      bus.stream_dat     = '0;
      bus.stream_valid   = 1'b0;
      bus.stream_send_BX = 1'b0;
      bus.stream_none    = 1'b0;
      bus.out_ready      = 1'b0;
      test_reset();
      test_basic();
      test_empty();
      test_overflow();
      test_trunc();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
